// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the four-digit seven-segment scanner.
//   NUM_DIGITS      - digits on the display
//   SEG_0..SEG_9    - active-low {g,f,e,d,c,b,a} glyph patterns
//   SEG_DASH        - pattern for non-decimal nibbles (segment g only)
//   SEG_OFF/AN_OFF  - all segments / all anodes dark
//   shadow_t        - frame-synchronous snapshot of the display inputs
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [7:0]            SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] bcd;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink_en;
        logic                    blank_lz;
    } shadow_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low segment pattern.
//   nibble_i - 4-bit digit value; A..F render as a dash
//   seg_o    - active-low {g,f,e,d,c,b,a}
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit time-multiplexed common-anode display driver.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bcd         - packed digits {d3,d2,d1,d0}, two independent 0-99 byte fields
//   dp_in       - decimal point request per digit
//   blink_en    - blink request per digit
//   blank_lz    - blank leading zero of each byte field (digits 3 and 1)
//   enable      - live display enable; counters run regardless
//   an          - active-low anode select, an[0] = rightmost digit
//   seg         - active-low {dp,g,f,e,d,c,b,a}
//   frame_done  - one-cycle pulse in the cycle after the shadow snapshot loads
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD        = 16,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_en,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]    presc_q;
    logic [IDX_W-1:0] idx_q;
    logic [FW-1:0]    frame_q;
    logic             blink_q;
    shadow_t          shadow_q;
    // Clears on reset so the aborted/first frame stays dark instead of
    // showing the all-zero reset snapshot.
    logic             valid_q;
    logic [3:0]       an_q;
    logic [7:0]       seg_q;
    logic             frame_done_q;

    logic             presc_wrap;
    logic             frame_wrap;
    logic [3:0]       nibble;
    logic [6:0]       pattern;
    logic             lz_blank;
    logic             dark;
    logic [3:0]       an_d;
    logic [7:0]       seg_d;

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (pattern)
    );

    always_comb begin
        presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
        frame_wrap = presc_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
        nibble     = shadow_q.bcd[{idx_q, 2'b00} +: 4];
        // Odd indices are the tens digit of each byte field.
        lz_blank   = shadow_q.blank_lz && idx_q[0] && (nibble == 4'd0);
        dark       = !valid_q
                  || (presc_q < PW'(GUARD))
                  || !enable
                  || (blink_q && shadow_q.blink_en[idx_q])
                  || lz_blank;
        an_d       = AN_OFF;
        seg_d      = SEG_OFF;
        if (!dark) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {~shadow_q.dp[idx_q], pattern};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            blink_q      <= 1'b0;
            shadow_q     <= '0;
            valid_q      <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_wrap;
            presc_q      <= presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (frame_wrap) begin
                shadow_q <= '{bcd: bcd, dp: dp_in, blink_en: blink_en, blank_lz: blank_lz};
                valid_q  <= 1'b1;
                if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frame_q <= frame_q + FW'(1);
                end
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int nchk = 0;
    int nerr = 0;
    int nb   = 0;   // frame boundaries since the last reset release

    seg7_scan #(
        .SCAN_DIV     (8),
        .GUARD        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd        (bcd),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples frame cycles lo..hi (1..32 after a frame_done). exp_seg holds
    // the visible seg byte per digit {d3,d2,d1,d0}; 8'hFF means digit dark.
    // Cycles dk_lo..dk_hi are driven with enable low one cycle ahead.
    task automatic check_span(input string name, input int lo, input int hi,
                              input logic [31:0] exp_seg, input int dk_lo, input int dk_hi);
        int         slot;
        int         pos;
        logic [7:0] s;
        logic [3:0] ea;
        logic [7:0] es;
        for (int j = lo; j <= hi; j++) begin
            @(negedge clk);
            slot = (j - 1) / 8;
            pos  = (j - 1) % 8;
            s    = exp_seg[slot*8 +: 8];
            if (pos < 2 || s == 8'hFF || (j >= dk_lo && j <= dk_hi)) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = 4'hF & ~(4'b0001 << slot);
                es = s;
            end
            check($sformatf("%s j%0d an", name, j), {28'd0, an}, {28'd0, ea});
            check($sformatf("%s j%0d seg", name, j), {24'd0, seg}, {24'd0, es});
            check($sformatf("%s j%0d frame_done", name, j), {31'd0, frame_done}, {31'd0, (j == 32)});
            if (j == 32) nb++;
            enable = !((j + 1) >= dk_lo && (j + 1) <= dk_hi);
        end
    endtask

    task automatic wait_frame();
        logic found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                nb++;
                break;
            end
        end
        check("wait_frame timeout", {31'd0, found}, 32'd1);
    endtask

    // After reset release: dark until the first frame_done, 32 cycles later.
    task automatic wait_first();
        logic found = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                nb = 1;
                check("first frame_done cycle", j, 32);
                break;
            end
            check($sformatf("pre-frame j%0d an/seg", j), {20'd0, an, seg}, 32'h00000FFF);
        end
        check("first frame_done timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        bcd      = 16'h1234;
        dp_in    = 4'b0000;
        blink_en = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset an", {28'd0, an}, 32'hF);
        check("reset seg", {24'd0, seg}, 32'hFF);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        wait_first();
        check_span("scan1234", 1, 32, 32'hF9A4B099, 0, -1);

        // Leading-zero blanking per byte field
        bcd      = 16'h0507;
        blank_lz = 1'b1;
        wait_frame();
        check_span("lz_on", 1, 32, 32'hFF92FFF8, 0, -1);
        blank_lz = 1'b0;
        wait_frame();
        check_span("lz_off", 1, 32, 32'hC092C0F8, 0, -1);

        // No tearing: mid-frame change waits for the next boundary
        bcd = 16'h1111;
        wait_frame();
        check_span("tear_a", 1, 12, 32'hF9F9F9F9, 0, -1);
        bcd = 16'h2222;
        check_span("tear_b", 13, 32, 32'hF9F9F9F9, 0, -1);
        check_span("tear_c", 1, 32, 32'hA4A4A4A4, 0, -1);

        // Blink on digit0, decimal point on digit2
        bcd      = 16'h1234;
        blink_en = 4'b0001;
        dp_in    = 4'b0100;
        wait_frame();
        for (int f = 0; f < 4; f++) begin
            logic [7:0] d0;
            d0 = (((nb / 2) % 2) == 1) ? 8'hFF : 8'h99;
            check_span($sformatf("blink f%0d", f), 1, 32, {8'hF9, 8'h24, 8'hB0, d0}, 0, -1);
        end

        // Invalid nibbles and a 3-cycle enable drop mid-slot
        bcd      = 16'hA0F0;
        blink_en = 4'b0000;
        dp_in    = 4'b0000;
        wait_frame();
        check_span("enable_drop", 1, 32, 32'hBFC0BFC0, 13, 15);

        // Asynchronous reset while a digit is lit
        check_span("pre_rst", 1, 20, 32'hBFC0BFC0, 0, -1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst an", {28'd0, an}, 32'hF);
        check("async rst seg", {24'd0, seg}, 32'hFF);
        check("async rst frame_done", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        wait_first();
        check_span("post_rst", 1, 32, 32'hBFC0BFC0, 0, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
